rgmii_rx_delay_cal: RTL and testbench

Calibration controller for the RGMII receive input delay lines (DELAYF, 128 taps × 25 ps). On request, it sweeps the shared delay tap from 0 upward and checks received frame preambles at each tap. It finds the first contiguous passing window, then parks the tap at the window centre. It sits beside the RGMII RX front end in the rx clock domain and drives the LOADN/MOVE/DIRECTION pins shared by the ctl and data delay lines.

---
 rtl/rgmii_rx_delay_cal_pkg.sv | 29 ++
 rtl/rgmii_preamble_checker.sv | 81 ++++++++
 rtl/rgmii_rx_delay_cal.sv | 270 +++++++++++++++++++++++++++
 tb/tb_rgmii_rx_delay_cal.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_rx_delay_cal_pkg.sv
// Shared definitions for the RGMII RX delay-line calibration controller.
package rgmii_rx_delay_cal_pkg;

    // Calibration sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REWIND,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_CENTER
    } cal_state_t;

    // Phases of a single delay-line step
    typedef enum logic [1:0] {
        MV_IDLE,
        MV_PULSE,
        MV_GAP
    } mv_phase_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

    // Minimum number of low cycles between two MOVE pulses
    localparam int MOVE_GAP = 3;

endpackage

// File: rtl/rgmii_preamble_checker.sv
// Checks the seven preamble/SFD bytes of each frame that starts while enabled.
// A frame already in flight when enable rises is skipped: only a fresh rising
// edge of rx_valid opens a frame. Emits registered one-cycle good/bad pulses.
module rgmii_preamble_checker
    import rgmii_rx_delay_cal_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_valid,
    input  logic       rx_error,
    input  logic [7:0] rx_data,
    output logic       frame_good,
    output logic       frame_bad
);

    logic       prev_valid_q, prev_valid_d;
    logic       in_frame_q, in_frame_d;
    logic [2:0] idx_q, idx_d;
    logic       good_q, good_d;
    logic       bad_q, bad_d;
    logic [7:0] exp_byte;
    logic       byte_ok;

    // Byte-by-byte preamble comparison and frame tracking
    always_comb begin
        prev_valid_d = rx_valid;
        in_frame_d   = in_frame_q;
        idx_d        = idx_q;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        exp_byte     = (idx_q == 3'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
        byte_ok      = !rx_error && (rx_data == exp_byte);

        if (!en) begin
            in_frame_d = 1'b0;
            idx_d      = '0;
        end else if (!in_frame_q) begin
            // idx_q is 0 here, so byte_ok checks against the preamble byte
            if (rx_valid && !prev_valid_q) begin
                if (byte_ok) begin
                    in_frame_d = 1'b1;
                    idx_d      = 3'd1;
                end else begin
                    bad_d = 1'b1;
                end
            end
        end else if (!rx_valid || !byte_ok) begin
            bad_d      = 1'b1;
            in_frame_d = 1'b0;
            idx_d      = '0;
        end else if (idx_q == 3'(PREAMBLE_LEN - 1)) begin
            good_d     = 1'b1;
            in_frame_d = 1'b0;
            idx_d      = '0;
        end else begin
            idx_d = idx_q + 3'd1;
        end
    end

    // Checker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
            in_frame_q   <= 1'b0;
            idx_q        <= '0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            prev_valid_q <= prev_valid_d;
            in_frame_q   <= in_frame_d;
            idx_q        <= idx_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
        end
    end

    assign frame_good = good_q;
    assign frame_bad  = bad_q;

endmodule

// File: rtl/rgmii_rx_delay_cal.sv
// RGMII RX input-delay calibration: rewinds the shared delay tap to 0, sweeps
// upward qualifying each tap on received preambles, and parks the tap at the
// centre of the first contiguous passing window (or back at INIT_TAP if none).
module rgmii_rx_delay_cal
    import rgmii_rx_delay_cal_pkg::*;
#(
    parameter int NUM_TAPS      = 128,
    parameter int TAP_W         = 7,
    parameter int INIT_TAP      = 80,
    parameter int SETTLE_CYCLES = 16,
    parameter int PASS_FRAMES   = 4,
    parameter int TIMEOUT       = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_valid,
    input  logic             rx_error,
    input  logic [7:0]       rx_data,
    output logic             dly_loadn,
    output logic             dly_move,
    output logic             dly_direction,
    output logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] win_lo,
    output logic [TAP_W-1:0] win_hi,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    localparam int CNT_W  = 20;
    localparam int GOOD_W = $clog2(PASS_FRAMES + 1);
    localparam int GAP_W  = $clog2(MOVE_GAP + 1);

    cal_state_t       state_q, state_d;
    mv_phase_t        mv_phase_q, mv_phase_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic             tap_pass_q, tap_pass_d;
    logic             seen_pass_q, seen_pass_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] win_lo_q, win_lo_d;
    logic [TAP_W-1:0] win_hi_q, win_hi_d;
    logic             dly_loadn_q, dly_loadn_d;
    logic             dly_move_q, dly_move_d;
    logic             dly_direction_q, dly_direction_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic             mv_start;
    logic             mv_dir;
    logic             mv_done;
    logic [TAP_W:0]   mid_sum;
    logic [TAP_W-1:0] target;
    logic             chk_en;
    logic             frame_good;
    logic             frame_bad;

    // One tap step in the given direction, saturating at both ends
    function automatic logic [TAP_W-1:0] step_tap(input logic [TAP_W-1:0] t,
                                                  input logic down);
        if (down)
            return (t == '0) ? t : t - TAP_W'(1);
        else
            return (t == TAP_W'(NUM_TAPS - 1)) ? t : t + TAP_W'(1);
    endfunction

    assign chk_en = (state_q == ST_SAMPLE);

    rgmii_preamble_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .en         (chk_en),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_data    (rx_data),
        .frame_good (frame_good),
        .frame_bad  (frame_bad)
    );

    // Sequencer next-state: move engine phases plus calibration state machine
    always_comb begin
        state_d         = state_q;
        mv_phase_d      = mv_phase_q;
        gap_cnt_d       = gap_cnt_q;
        cnt_d           = cnt_q;
        good_cnt_d      = good_cnt_q;
        tap_pass_d      = tap_pass_q;
        seen_pass_d     = seen_pass_q;
        tap_d           = tap_q;
        win_lo_d        = win_lo_q;
        win_hi_d        = win_hi_q;
        dly_loadn_d     = 1'b1;
        dly_move_d      = 1'b0;
        dly_direction_d = dly_direction_q;
        busy_d          = busy_q;
        done_d          = done_q;
        fail_d          = fail_q;
        mv_start        = 1'b0;
        mv_dir          = dly_direction_q;
        mv_done         = 1'b0;
        mid_sum         = {1'b0, win_lo_q} + {1'b0, win_hi_q};
        target          = seen_pass_q ? mid_sum[TAP_W:1] : TAP_W'(INIT_TAP);

        // Direction is already registered when the pulse phase starts, so it
        // is stable one cycle before and during the pulse.
        case (mv_phase_q)
            MV_PULSE: begin
                dly_move_d = 1'b1;
                tap_d      = step_tap(tap_q, dly_direction_q);
                mv_phase_d = MV_GAP;
                gap_cnt_d  = '0;
            end
            MV_GAP: begin
                if (gap_cnt_q == GAP_W'(MOVE_GAP - 1)) begin
                    mv_phase_d = MV_IDLE;
                    mv_done    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    seen_pass_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dly_loadn_d = 1'b0;
                tap_d       = TAP_W'(INIT_TAP);
                mv_phase_d  = MV_IDLE;
                state_d     = ST_REWIND;
            end
            ST_REWIND: begin
                if (mv_phase_q == MV_IDLE) begin
                    if (tap_q != '0) begin
                        mv_start = 1'b1;
                        mv_dir   = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d    = ST_SAMPLE;
                    cnt_d      = '0;
                    good_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (frame_bad) begin
                    tap_pass_d = 1'b0;
                    state_d    = ST_EVAL;
                end else if (frame_good && good_cnt_q == GOOD_W'(PASS_FRAMES - 1)) begin
                    // checked ahead of the timeout so a tie counts as a pass
                    tap_pass_d = 1'b1;
                    state_d    = ST_EVAL;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tap_pass_d = 1'b0;
                    state_d    = ST_EVAL;
                end else if (frame_good) begin
                    good_cnt_d = good_cnt_q + GOOD_W'(1);
                end
            end
            ST_EVAL: begin
                if (mv_phase_q == MV_IDLE) begin
                    if (tap_pass_q) begin
                        if (!seen_pass_q) begin
                            win_lo_d    = tap_q;
                            seen_pass_d = 1'b1;
                        end
                        win_hi_d = tap_q;
                    end
                    if ((!tap_pass_q && seen_pass_q) || tap_q == TAP_W'(NUM_TAPS - 1)) begin
                        state_d = ST_CENTER;
                    end else begin
                        mv_start = 1'b1;
                        mv_dir   = 1'b0;
                    end
                end else if (mv_done) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_CENTER: begin
                if (mv_phase_q == MV_IDLE) begin
                    if (tap_q == target) begin
                        done_d  = seen_pass_q;
                        fail_d  = !seen_pass_q;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        mv_start = 1'b1;
                        mv_dir   = (tap_q > target);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (mv_start) begin
            dly_direction_d = mv_dir;
            mv_phase_d      = MV_PULSE;
        end
    end

    // Sequencer and registered-output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            mv_phase_q      <= MV_IDLE;
            gap_cnt_q       <= '0;
            cnt_q           <= '0;
            good_cnt_q      <= '0;
            tap_pass_q      <= 1'b0;
            seen_pass_q     <= 1'b0;
            tap_q           <= TAP_W'(INIT_TAP);
            win_lo_q        <= '0;
            win_hi_q        <= '0;
            dly_loadn_q     <= 1'b1;
            dly_move_q      <= 1'b0;
            dly_direction_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mv_phase_q      <= mv_phase_d;
            gap_cnt_q       <= gap_cnt_d;
            cnt_q           <= cnt_d;
            good_cnt_q      <= good_cnt_d;
            tap_pass_q      <= tap_pass_d;
            seen_pass_q     <= seen_pass_d;
            tap_q           <= tap_d;
            win_lo_q        <= win_lo_d;
            win_hi_q        <= win_hi_d;
            dly_loadn_q     <= dly_loadn_d;
            dly_move_q      <= dly_move_d;
            dly_direction_q <= dly_direction_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            fail_q          <= fail_d;
        end
    end

    assign dly_loadn     = dly_loadn_q;
    assign dly_move      = dly_move_q;
    assign dly_direction = dly_direction_q;
    assign tap           = tap_q;
    assign win_lo        = win_lo_q;
    assign win_hi        = win_hi_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;

endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// Bench for rgmii_rx_delay_cal: a delay-line model driven by the DUT pins
// shapes a periodic preamble stream; calibration cases come from a table.
module tb_rgmii_rx_delay_cal;

    localparam int NUM_TAPS      = 128;
    localparam int TAP_W         = 7;
    localparam int INIT_TAP      = 80;
    localparam int SETTLE_CYCLES = 16;
    localparam int PASS_FRAMES   = 4;
    localparam int TIMEOUT       = 64;
    localparam int FRAME_PERIOD  = 12;
    localparam int FRAME_LEN     = 8;
    localparam int RUN_LIMIT     = 40000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             rx_valid;
    logic             rx_error;
    logic [7:0]       rx_data;
    logic             dly_loadn;
    logic             dly_move;
    logic             dly_direction;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] win_lo;
    logic [TAP_W-1:0] win_hi;
    logic             busy;
    logic             done;
    logic             fail;

    always #5 clk = ~clk;

    rgmii_rx_delay_cal #(
        .NUM_TAPS      (NUM_TAPS),
        .TAP_W         (TAP_W),
        .INIT_TAP      (INIT_TAP),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .PASS_FRAMES   (PASS_FRAMES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .rx_data       (rx_data),
        .dly_loadn     (dly_loadn),
        .dly_move      (dly_move),
        .dly_direction (dly_direction),
        .tap           (tap),
        .win_lo        (win_lo),
        .win_hi        (win_hi),
        .busy          (busy),
        .done          (done),
        .fail          (fail)
    );

    // Channel configuration: taps cfg_lo..cfg_hi give clean preambles
    int cfg_lo     = 0;
    int cfg_hi     = -1;
    int cfg_bad    = -1;
    bit traffic_on = 1'b0;

    // Delay-line model plus MOVE/LOADN protocol monitor
    int   mtap       = 0;
    int   up_moves   = 0;
    int   down_moves = 0;
    int   proto_err  = 0;
    int   since_move = 100;
    logic prev_dir   = 1'b0;
    logic prev_loadn = 1'b1;

    always @(negedge clk) begin
        if (!dly_loadn)
            mtap <= INIT_TAP;
        else if (dly_move && dly_direction && mtap > 0)
            mtap <= mtap - 1;
        else if (dly_move && !dly_direction && mtap < NUM_TAPS - 1)
            mtap <= mtap + 1;
        if (dly_move && dly_direction)  down_moves <= down_moves + 1;
        if (dly_move && !dly_direction) up_moves   <= up_moves + 1;
        proto_err <= proto_err
                     + ((dly_move && dly_direction != prev_dir) ? 1 : 0)
                     + ((dly_move && since_move < 3) ? 1 : 0)
                     + ((!dly_loadn && !prev_loadn) ? 1 : 0);
        since_move <= dly_move ? 0 : since_move + 1;
        prev_dir   <= dly_direction;
        prev_loadn <= dly_loadn;
    end

    // Periodic frame generator: 7 preamble/SFD bytes + 1 payload byte, then idle
    initial begin
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
        forever begin
            for (int b = 0; b < FRAME_PERIOD; b++) begin
                @(posedge clk);
                #1;
                if (!traffic_on || b >= FRAME_LEN) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'h00;
                end else begin
                    rx_valid = 1'b1;
                    rx_data  = (b < 6) ? 8'h55 : (b == 6) ? 8'hD5 : 8'h00;
                    if (mtap < cfg_lo || mtap > cfg_hi)
                        rx_data = rx_data ^ 8'h0F;
                    else if (mtap == cfg_bad && b == 3)
                        rx_data = 8'h54;
                end
            end
        end
    end

    typedef struct {
        int lo;
        int hi;
        int bad;
        bit traffic;
        bit exp_done;
        bit exp_fail;
        bit chk_win;
        int exp_lo;
        int exp_hi;
        int exp_tap;
        int exp_up;
        int exp_down;
    } vec_t;

    vec_t vecs [5];
    vec_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive one calibration, then compare against the queued expectation
    task automatic run_cal(input vec_t v, input int id);
        vec_t e;
        int   up0, dn0, cyc;
        cfg_lo     = v.lo;
        cfg_hi     = v.hi;
        cfg_bad    = v.bad;
        traffic_on = v.traffic;
        up0 = up_moves;
        dn0 = down_moves;
        sb_q.push_back(v);
        pulse_start();
        chk($sformatf("case%0d busy_after_start", id), int'(busy), 1);
        repeat (50) tick();
        pulse_start();
        cyc = 0;
        while (busy && cyc < RUN_LIMIT) begin
            tick();
            cyc++;
        end
        e = sb_q.pop_front();
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL case%0d completion: still busy after %0d cycles, expected idle", id, RUN_LIMIT);
        end
        chk($sformatf("case%0d done", id), int'(done), int'(e.exp_done));
        chk($sformatf("case%0d fail", id), int'(fail), int'(e.exp_fail));
        chk($sformatf("case%0d tap", id), int'(tap), e.exp_tap);
        chk($sformatf("case%0d line_tap", id), mtap, e.exp_tap);
        chk($sformatf("case%0d up_moves", id), up_moves - up0, e.exp_up);
        chk($sformatf("case%0d down_moves", id), down_moves - dn0, e.exp_down);
        if (e.chk_win) begin
            chk($sformatf("case%0d win_lo", id), int'(win_lo), e.exp_lo);
            chk($sformatf("case%0d win_hi", id), int'(win_hi), e.exp_hi);
        end
    endtask

    initial begin
        int cyc;
        //          lo   hi  bad  trf done fail win  elo  ehi  etap up   down
        vecs[0] = '{20,  40,  -1, 1,  1,   0,   1,   20,  40,  30,  41,  91};
        vecs[1] = '{200, -1,  -1, 1,  0,   1,   0,   0,   0,   80,  127, 127};
        vecs[2] = '{100, 127, -1, 1,  1,   0,   1,   100, 127, 113, 127, 94};
        vecs[3] = '{0,   127, -1, 0,  0,   1,   0,   0,   0,   80,  127, 127};
        vecs[4] = '{20,  40,  25, 1,  1,   0,   1,   20,  24,  22,  25,  83};

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst dly_loadn", int'(dly_loadn), 1);
        chk("rst dly_move", int'(dly_move), 0);
        chk("rst dly_direction", int'(dly_direction), 0);
        chk("rst tap", int'(tap), INIT_TAP);
        chk("rst win_lo", int'(win_lo), 0);
        chk("rst win_hi", int'(win_hi), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst fail", int'(fail), 0);

        for (int i = 0; i < 5; i++)
            run_cal(vecs[i], i);

        // Reset while sampling at tap 30 during an upward sweep
        cfg_lo     = 20;
        cfg_hi     = 40;
        cfg_bad    = -1;
        traffic_on = 1'b1;
        pulse_start();
        cyc = 0;
        while (tap != 0 && cyc < RUN_LIMIT) begin tick(); cyc++; end
        while (tap != 30 && cyc < RUN_LIMIT) begin tick(); cyc++; end
        chk("midrst reached_tap30", int'(tap), 30);
        repeat (25) tick();
        chk("midrst busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst tap", int'(tap), INIT_TAP);
        chk("midrst dly_move", int'(dly_move), 0);
        chk("midrst dly_loadn", int'(dly_loadn), 1);
        chk("midrst done", int'(done), 0);
        chk("midrst win_lo", int'(win_lo), 0);
        repeat (5) tick();
        run_cal(vecs[0], 5);

        chk("move_protocol violations", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
